cyber_player: RTL
=================

Name: cyber_player

Overview:
- Computer-controlled opponent for the tug-of-war game.
- Generates the press/release stream that a human player would otherwise produce on a KEY input. It is the transmitter end of the player-button interface that tow consumes.
- Each game tick, it compares a free-running LFSR value against a switch-selected difficulty and issues one clean press pulse followed by a release gap.
- Instantiated at the tow top level; its press output drives the right-player input path in place of KEY[0].

Parameters:
SEED, 10'h001, LFSR reset value; must be nonzero
HOLD_TICKS, 1, number of ticks press stays high (1..15)
COOLDOWN_TICKS, 1, number of ticks press stays low after a press before the next decision (1..15)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset_n  input  1  asynchronous active-low reset
tick_en  input  1  single-cycle game-tick strobe from the clock divider; all state advances only on cycles where it is high
halt  input  1  game over / freeze; held high while a winner is displayed
difficulty  input  9  press threshold (SW[8:0]); 0 = never press
press  output  1  registered player press, active-high
lfsr  output  10  current LFSR state, for debug and verification

Behaviour:
- Reset (reset_n low, async):
  - press=0, lfsr=SEED, state=IDLE, tick counter=0.
  - Release is synchronous to the next clk edge.
- LFSR:
  - 10-bit Fibonacci, maximal length (period 1023).
  - On each edge with tick_en=1 and halt=0: lfsr <= {lfsr[8:0], lfsr[9]^lfsr[6]}.
  - If lfsr is ever 0, it reloads SEED on the next advance.
  - Frozen when tick_en=0 or halt=1.
- Decision compare: hit = ({1'b0,difficulty} > lfsr), unsigned 10-bit. It uses the pre-advance lfsr value of that same edge.
- FSM, evaluated only on tick_en=1 edges with halt=0:
  - IDLE: if hit, go to PRESS, set press=1, load counter=HOLD_TICKS-1. Else stay in IDLE with press=0.
  - PRESS: if counter==0, go to RELEASE, set press=0, load counter=COOLDOWN_TICKS-1. Else decrement the counter.
  - RELEASE: if counter==0, go to IDLE. Else decrement the counter. press stays 0.
- Result: each press is guaranteed to be followed by at least one low tick, so downstream edge detection counts exactly one pull per pulse.
- halt=1 on any edge (tick_en ignored): state <= IDLE, press <= 0, counter <= 0, lfsr holds.
  - Deasserting halt resumes in IDLE with the held lfsr value.
- Mid-pulse reset: press drops asynchronously; no partial pulse is remembered.
- Difficulty changes take effect at the next IDLE decision only, never mid-pulse.
- Latency: press rises on the same edge that samples hit, so it is registered with one-tick latency from the decision.

Optional Feature:
CYBER_PRESS_CNT_EN
- Defined:
  - Adds output press_count[7:0], reset 0.
  - Increments on each IDLE->PRESS transition and saturates at 255.
  - Cleared by halt rising edge, i.e. a new round.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tow_pkg:
  - typedef enum logic [1:0] {IDLE, PRESS, RELEASE} cyber_state_t
  - localparam LFSR_W=10
  - localparam LFSR_TAP_HI=9, LFSR_TAP_LO=6
- Sub-module lfsr10 contains the shift register, tick enable, zero-lock recovery and SEED parameter.
- cyber_player holds the compare, the FSM, the tick counter and the optional counter.

Test Plan:
1. Reset with reset_n=0 mid-run, then release -> press=0, lfsr=10'h001, press stays 0 until the first tick_en.
2. difficulty=511, tick_en=1 every cycle, halt=0, defaults:
   - lfsr steps 1,2,4,8,16,32,64,129,...
   - press pattern is 1,0,0,1,0,0,... starting on the first edge and repeating while lfsr<511.
   - press never high on two consecutive ticks.
3. difficulty=0, 2000 ticks -> press never asserts; lfsr returns to 10'h001 after 1023 ticks.
4. tick_en pulsed every 4th cycle -> lfsr and FSM move only on strobe edges; press holds for exactly 4 clk cycles per HOLD tick.
5. Assert halt while press=1 -> press=0 next edge, lfsr frozen; drop halt -> resumes from IDLE with the same lfsr value.
6. CYBER_PRESS_CNT_EN defined, HOLD_TICKS=2, COOLDOWN_TICKS=3, difficulty=511:
   - press width is 2 ticks and the gap is at least 3 ticks.
   - press_count equals the number of rising edges of press, saturating at 255 and cleared on halt rise.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war game blocks.
// Holds the cyber player FSM encoding and the LFSR geometry/step function.
package tow_pkg;

  localparam int unsigned LFSR_W      = 10;
  localparam int unsigned LFSR_TAP_HI = 9;
  localparam int unsigned LFSR_TAP_LO = 6;
  localparam int unsigned TICK_CNT_W  = 4;
  localparam int unsigned PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE
  } cyber_state_t;

  // One Fibonacci step; an all-zero state is stuck, so it recovers to the seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur,
                                                   input logic [LFSR_W-1:0] seed);
    if (cur == '0) begin
      return seed;
    end
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit maximal-length Fibonacci LFSR that steps only on unhalted game ticks.
// A zero state reloads SEED on the next step.
module lfsr10
  import tow_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 10'h001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick_en,
  input  logic              halt,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (tick_en && !halt) begin
      value_d = lfsr_next(value_q, SEED);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/cyber_player.sv
// Computer-controlled tug-of-war opponent: LFSR-vs-difficulty press decisions.
// Optional CYBER_PRESS_CNT_EN adds a saturating press_count output.
module cyber_player
  import tow_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED           = 10'h001,
  parameter int unsigned       HOLD_TICKS     = 1,
  parameter int unsigned       COOLDOWN_TICKS = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick_en,
  input  logic                   halt,
  input  logic [LFSR_W-2:0]      difficulty,
  output logic                   press,
`ifdef CYBER_PRESS_CNT_EN
  output logic [PRESS_CNT_W-1:0] press_count,
`endif
  output logic [LFSR_W-1:0]      lfsr
);

  localparam logic [TICK_CNT_W-1:0] HOLD_LD = TICK_CNT_W'(HOLD_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] COOL_LD = TICK_CNT_W'(COOLDOWN_TICKS - 1);

  cyber_state_t          state_q, state_d;
  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
  logic                  press_q, press_d;
  logic [LFSR_W-1:0]     lfsr_value;
  logic                  hit;

  lfsr10 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_en(tick_en),
    .halt   (halt),
    .value  (lfsr_value)
  );

  // Pre-advance LFSR value is compared on the same edge that steps it.
  assign hit = {1'b0, difficulty} > lfsr_value;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = press_q;
    if (halt) begin
      state_d = IDLE;
      cnt_d   = '0;
      press_d = 1'b0;
    end else if (tick_en) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_d = PRESS;
            press_d = 1'b1;
            cnt_d   = HOLD_LD;
          end else begin
            press_d = 1'b0;
          end
        end
        PRESS: begin
          if (cnt_q == '0) begin
            state_d = RELEASE;
            press_d = 1'b0;
            cnt_d   = COOL_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RELEASE: begin
          press_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          press_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
  assign lfsr  = lfsr_value;

`ifdef CYBER_PRESS_CNT_EN
  logic                   enter_press;
  logic                   halt_q;
  logic [PRESS_CNT_W-1:0] press_cnt_q;

  assign enter_press = (state_q == IDLE) && (state_d == PRESS);

  // A rising halt marks the end of a round, so the tally restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      halt_q <= halt;
      if (halt && !halt_q) begin
        press_cnt_q <= '0;
      end else if (enter_press && (press_cnt_q != '1)) begin
        press_cnt_q <= press_cnt_q + 1'b1;
      end
    end
  end

  assign press_count = press_cnt_q;
`endif

endmodule
